// File: rtl/controle_multiciclo.sv
// Multicycle control unit for a small RV32I subset.
// The unit latches the instruction, steps FETCH -> DECODE -> EXEC -> [MEM] -> PCUPD,
// and drives the datapath strobes. The PC stage advances only while estado == PCUPD.
// Handshake: the data memory raises mem_pronta for one cycle while estado == MEM to
// complete the access; the unit holds memread/memwrite high until then, or until
// MEM_TIMEOUT cycles have elapsed, which aborts the instruction as illegal.
module controle_multiciclo #(
  parameter int MEM_TIMEOUT = 15,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instrucao,
  input  logic                 zero,
  input  logic                 mem_pronta,
  output logic [2:0]           estado,
  output logic                 pcsrc,
  output logic [11:0]          immediate,
  output logic                 ir_write,
  output logic                 regwrite,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 alusrc,
  output logic [1:0]           aluop,
  output logic                 ilegal,
  output logic [INSTRET_W-1:0] instret
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_PCUPD  = 3'b100
  } state_e;

  state_e                 estado_q, estado_d;
  logic [31:0]            ir_q, ir_d;
  logic                   zero_l_q, zero_l_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   abort_q, abort_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   ilegal_q, ilegal_d;
  logic                   pcsrc_q, pcsrc_d;
  logic                   ir_write_q, ir_write_d;
  logic                   regwrite_q, regwrite_d;
  logic                   memread_q, memread_d;
  logic                   memwrite_q, memwrite_d;

  logic is_r, is_addi, is_lw, is_sw, is_beq, is_supported;

  // The rs1 field and funct3 are consumed by the datapath, not by this unit.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir_q[19:12];

  // Opcode class of the latched instruction.
  always_comb begin
    is_r         = (ir_q[6:0] == OP_R);
    is_addi      = (ir_q[6:0] == OP_ADDI);
    is_lw        = (ir_q[6:0] == OP_LW);
    is_sw        = (ir_q[6:0] == OP_SW);
    is_beq       = (ir_q[6:0] == OP_BEQ);
    is_supported = is_r | is_addi | is_lw | is_sw | is_beq;
  end

  // Immediate and ALU controls, decoded straight from the latched instruction.
  always_comb begin
    immediate = 12'h000;
    alusrc    = 1'b0;
    aluop     = 2'b00;
    if (is_addi || is_lw) begin
      immediate = ir_q[31:20];
      alusrc    = 1'b1;
    end else if (is_sw) begin
      immediate = {ir_q[31:25], ir_q[11:7]};
      alusrc    = 1'b1;
    end else if (is_beq) begin
      immediate = {ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8]};
      aluop     = 2'b01;
    end else if (is_r) begin
      aluop     = 2'b10;
    end
  end

  // Next state, datapath bookkeeping, and the strobes that belong to the next state.
  always_comb begin
    estado_d  = estado_q;
    ir_d      = ir_q;
    zero_l_d  = zero_l_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    instret_d = instret_q;
    ilegal_d  = 1'b0;
    case (estado_q)
      S_FETCH: begin
        ir_d     = instrucao;
        cnt_d    = '0;
        abort_d  = 1'b0;
        estado_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_supported) begin
          estado_d = S_EXEC;
        end else begin
          estado_d = S_PCUPD;
          ilegal_d = 1'b1;
          abort_d  = 1'b1;
        end
      end
      S_EXEC: begin
        zero_l_d = zero;
        estado_d = (is_lw || is_sw) ? S_MEM : S_PCUPD;
      end
      S_MEM: begin
        if (mem_pronta) begin
          estado_d = S_PCUPD;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          // This is the MEM_TIMEOUT-th cycle without ready: give up.
          estado_d = S_PCUPD;
          ilegal_d = 1'b1;
          abort_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PCUPD: begin
        estado_d = S_FETCH;
        if (!abort_q) instret_d = instret_q + INSTRET_W'(1);
      end
      default: estado_d = S_FETCH;
    endcase

    ir_write_d = (estado_d == S_FETCH);
    memread_d  = (estado_d == S_MEM) & is_lw;
    memwrite_d = (estado_d == S_MEM) & is_sw;
    regwrite_d = (estado_d == S_PCUPD) & (is_r | is_addi | is_lw) & ~abort_d;
    pcsrc_d    = (estado_d == S_PCUPD) & is_beq & zero_l_d;
  end

  // State register with registered outputs; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= S_FETCH;
      ir_q       <= '0;
      zero_l_q   <= 1'b0;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      instret_q  <= '0;
      ilegal_q   <= 1'b0;
      pcsrc_q    <= 1'b0;
      ir_write_q <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      ir_q       <= ir_d;
      zero_l_q   <= zero_l_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      instret_q  <= instret_d;
      ilegal_q   <= ilegal_d;
      pcsrc_q    <= pcsrc_d;
      ir_write_q <= ir_write_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
    end
  end

  assign estado   = estado_q;
  assign pcsrc    = pcsrc_q;
  assign ir_write = ir_write_q;
  assign regwrite = regwrite_q;
  assign memread  = memread_q;
  assign memwrite = memwrite_q;
  assign ilegal   = ilegal_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: table of instructions stepped cycle by cycle
// through a reference state model, plus reset-in-MEM and counter-wrap sequences.
module tb_controle_multiciclo;

  localparam int RW = 4;  // narrow retire counter so wrap-around is reachable

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] PCUPD  = 3'd4;

  localparam logic [2:0] K_R = 3'd0, K_ADDI = 3'd1, K_LW = 3'd2;
  localparam logic [2:0] K_SW = 3'd3, K_BEQ = 3'd4, K_ILL = 3'd5;

  localparam int OW = 3 + 1 + 12 + 1 + 1 + 1 + 1 + 1 + 2 + 1 + RW;
  localparam int NVEC = 13;

  typedef struct {
    logic [31:0] ins;
    logic        z;
    int          w;       // MEM cycles with mem_pronta low before it rises (99 = never)
    logic [2:0]  kind;
    logic [11:0] imm;
    logic        alusrc;
    logic [1:0]  aluop;
    int          lat;     // cycles from FETCH back to FETCH
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [31:0]   instrucao;
  logic          zero;
  logic          mem_pronta;
  logic [2:0]    estado;
  logic          pcsrc;
  logic [11:0]   immediate;
  logic          ir_write, regwrite, memread, memwrite, alusrc, ilegal;
  logic [1:0]    aluop;
  logic [RW-1:0] instret;

  controle_multiciclo #(.MEM_TIMEOUT(15), .INSTRET_W(RW)) dut (
    .clk(clk), .reset(reset), .instrucao(instrucao), .zero(zero),
    .mem_pronta(mem_pronta), .estado(estado), .pcsrc(pcsrc),
    .immediate(immediate), .ir_write(ir_write), .regwrite(regwrite),
    .memread(memread), .memwrite(memwrite), .alusrc(alusrc), .aluop(aluop),
    .ilegal(ilegal), .instret(instret)
  );

  logic [OW-1:0] dut_word;
  assign dut_word = {estado, pcsrc, immediate, ir_write, regwrite, memread,
                     memwrite, alusrc, aluop, ilegal, instret};

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  vec_t          vecs[NVEC];
  logic          m_zl;
  logic [RW-1:0] m_ret;

  task automatic check_out(input int tag, input int cyc);
    logic [OW-1:0] e;
    e = exp_q.pop_front();
    checks++;
    if (dut_word !== e) begin
      errors++;
      $display("FAIL out vec%0d cyc%0d got %h exp %h (estado %0d/%0d)",
               tag, cyc, dut_word, e, estado, e[OW-1 -: 3]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  // ---------------- driver + reference model ----------------
  // Steps one instruction from FETCH; stop_after > 0 leaves it mid-flight.
  task automatic run_vec(input int idx, input int stop_after);
    vec_t v;
    logic [2:0] st, nst;
    logic ab, pcs, irw, rw, mr, mw, il;
    int k, cyc;
    v = vecs[idx];
    st = FETCH; k = 0; ab = 1'b0; cyc = 0;
    while (1) begin
      instrucao  = v.ins;
      zero       = (st == EXEC) ? v.z : 1'($urandom_range(0, 1));
      mem_pronta = (st == MEM) ? (k >= v.w) : 1'($urandom_range(0, 1));
      nst = FETCH;
      case (st)
        FETCH:  nst = DECODE;
        DECODE: if (v.kind == K_ILL) begin nst = PCUPD; ab = 1'b1; end
                else nst = EXEC;
        EXEC: begin
          m_zl = v.z;
          nst = (v.kind == K_LW || v.kind == K_SW) ? MEM : PCUPD;
        end
        MEM: begin
          if (k >= v.w) nst = PCUPD;
          else if (k == 14) begin nst = PCUPD; ab = 1'b1; end
          else begin nst = MEM; k++; end
        end
        default: begin
          nst = FETCH;
          if (!ab) m_ret = m_ret + 1'b1;
        end
      endcase
      pcs = (nst == PCUPD) && v.kind == K_BEQ && m_zl;
      irw = (nst == FETCH);
      rw  = (nst == PCUPD) && !ab &&
            (v.kind == K_R || v.kind == K_ADDI || v.kind == K_LW);
      mr  = (nst == MEM) && v.kind == K_LW;
      mw  = (nst == MEM) && v.kind == K_SW;
      il  = (nst == PCUPD) && ab;
      exp_q.push_back({nst, pcs, v.imm, irw, rw, mr, mw, v.alusrc, v.aluop, il, m_ret});
      @(posedge clk); #1;
      check_out(idx, cyc);
      st = nst;
      cyc++;
      if (st == FETCH) break;
      if (stop_after > 0 && cyc == stop_after) return;
      if (cyc > 40) begin
        check_int("latency_bound", cyc, v.lat);
        return;
      end
    end
    check_int("latency", cyc, v.lat);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instrucao = $urandom;
    zero = 1'b1;
    mem_pronta = 1'b1;
    exp_q.push_back('0);
    @(posedge clk); #1;
    check_out(-1, 0);
    reset = 1'b0;
    m_ret = '0;
    m_zl = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0]  = '{32'h00500093, 1'b0, 0,  K_ADDI, 12'h005, 1'b1, 2'b00, 4};
    vecs[1]  = '{32'h00000463, 1'b1, 0,  K_BEQ,  12'h004, 1'b0, 2'b01, 4};
    vecs[2]  = '{32'h00000463, 1'b0, 0,  K_BEQ,  12'h004, 1'b0, 2'b01, 4};
    vecs[3]  = '{32'h00402103, 1'b0, 3,  K_LW,   12'h004, 1'b1, 2'b00, 8};
    vecs[4]  = '{32'h00112623, 1'b0, 99, K_SW,   12'h00C, 1'b1, 2'b00, 19};
    vecs[5]  = '{32'hFFFFFFFF, 1'b1, 0,  K_ILL,  12'h000, 1'b0, 2'b00, 3};
    vecs[6]  = '{32'h002081B3, 1'b1, 0,  K_R,    12'h000, 1'b0, 2'b10, 4};
    vecs[7]  = '{32'h00402103, 1'b0, 0,  K_LW,   12'h004, 1'b1, 2'b00, 5};
    vecs[8]  = '{32'h00112623, 1'b0, 2,  K_SW,   12'h00C, 1'b1, 2'b00, 7};
    vecs[9]  = '{32'hFFF00093, 1'b0, 0,  K_ADDI, 12'hFFF, 1'b1, 2'b00, 4};
    vecs[10] = '{32'hFE000EE3, 1'b1, 0,  K_BEQ,  12'hFFE, 1'b0, 2'b01, 4};
    vecs[11] = '{32'h00402103, 1'b0, 99, K_LW,   12'h004, 1'b1, 2'b00, 19};
    vecs[12] = '{32'h00112623, 1'b0, 14, K_SW,   12'h00C, 1'b1, 2'b00, 19};

    reset = 1'b1;
    instrucao = '0;
    zero = 1'b0;
    mem_pronta = 1'b0;
    m_ret = '0;
    m_zl = 1'b0;
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < NVEC; i++) run_vec(i, 0);

    // Reset while waiting in MEM for a load that never completes.
    run_vec(11, 5);
    check_int("in_mem_before_reset", int'(estado), int'(MEM));
    do_reset();
    run_vec(0, 0);
    check_int("instret_after_reset", int'(instret), 1);

    // Sixteen more retires wrap the 4-bit counter back to 1.
    for (int i = 0; i < 16; i++) run_vec(0, 0);
    check_int("instret_wrap", int'(instret), 1);
    check_int("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
